bus_arb_mux: RTL

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

---
 rtl/bus_arb_pkg.sv | 6 +
 rtl/arb_pick.sv | 26 ++
 rtl/bus_arb_mux.sv | 67 ++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state encodings and arbitration mode constants
package bus_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner search, fixed priority or rotating from a start index
module arb_pick
   import bus_arb_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CW   = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [CW-1:0]   start,
   input  logic            mode,
   output logic            valid,
   output logic [CW-1:0]   idx
);
   int base, c;
   always_comb begin
      valid = |req;
      idx   = '0;
      c     = 0;
      base  = (mode == 1'(MODE_RR)) ? int'(start) : 0;
      // descending scan so the smallest offset from base is written last
      for (int i = N_CH - 1; i >= 0; i--) begin
         c = (base + i) % N_CH;
         if (req[c[CW-1:0]]) idx = c[CW-1:0];
      end
   end
endmodule

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: N-channel bus arbiter with hold limit, turnaround cycle and tri-state data mux
module bus_arb_mux
   import bus_arb_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4,
   parameter int MODE     = 1,
   localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       req,
   input  logic [N_CH*WIDTH-1:0] data_in,
   output tri   [WIDTH-1:0]      bus_out,
   output logic [N_CH-1:0]       grant,
   output logic [CW-1:0]         owner,
   output logic                  busy
);
   state_t          state, state_nx;
   logic [7:0]      hold_cnt;
   logic [CW-1:0]   last_owner, start, win;
   logic            win_v, own_req, others, expire, enter;
   logic [N_CH-1:0] grant_nx;
   assign start   = (last_owner == CW'(N_CH - 1)) ? '0 : last_owner + 1'b1;
   assign own_req = |(req & grant);
   assign others  = |(req & ~grant);
   assign expire  = hold_cnt == 8'(MAX_HOLD - 1);
   assign busy    = |grant;
   arb_pick #(.N_CH(N_CH), .CW(CW)) u_pick (
      .req   (req),
      .start (start),
      .mode  (MODE == MODE_RR),
      .valid (win_v),
      .idx   (win)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         owner      <= '0;
         hold_cnt   <= '0;
         last_owner <= CW'(N_CH - 1);
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         hold_cnt <= enter ? '0 : (state == GRANT && !expire) ? hold_cnt + 8'd1 : hold_cnt;
         if (enter) begin
            owner      <= win;
            last_owner <= win;
         end
      end
   end
   // TURN behaves like IDLE for the next decision, but is only ever one cycle long
   always_comb begin
      state_nx = (state == GRANT) ? ((!own_req || (expire && others)) ? TURN : GRANT)
                                  : (win_v ? GRANT : IDLE);
   end
   always_comb begin
      enter    = state_nx == GRANT && state != GRANT;
      grant_nx = enter ? {{(N_CH-1){1'b0}}, 1'b1} << win : (state_nx == GRANT ? grant : '0);
   end
   // data path is purely combinational, enabled only by the registered grant
   for (genvar k = 0; k < N_CH; k++) begin : g_drv
      assign bus_out = grant[k] ? data_in[k*WIDTH +: WIDTH] : {WIDTH{1'bz}};
   end
endmodule
